// File: rtl/mcp3201_emu.sv
// MCP3201 12-bit ADC slave emulator.
// Shifts a held sample out on an asynchronous SPI bus.
`timescale 1ns/1ps
module mcp3201_emu #(
  parameter int SYNC_STAGES = 2,
  parameter bit TAIL_EN     = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] sample_in,
  input  logic        sample_valid,
  input  logic        sclk_pin,
  input  logic        cs_pin_n,
  output logic        dout_pin,
  output logic        dout_oe,
  output logic        busy,
  output logic        conv_start,
  output logic        frame_done,
  output logic        frame_abort
);

  typedef enum logic [2:0] {
    IDLE, SAMPLE, NULLB, MSB, TAIL, ZERO
  } state_t;

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES:0]   r_vld;
  logic                   r_sclk_d;
  logic                   r_cs_d;
  logic [11:0]            r_hold;
  logic [11:0]            r_shift;
  state_t                 r_state;
  logic [4:0]             r_f;
  logic                   r_dout;
  logic                   r_oe;
  logic                   r_start;
  logic                   r_done;
  logic                   r_abort;

  logic       w_sclk_s;
  logic       w_cs_s;
  logic       w_sclk_fall;
  logic       w_cs_fall;
  logic       w_cs_rise;
  logic       w_capture;
  logic [4:0] w_f_inc;
  logic [3:0] w_msb_idx;
  logic [3:0] w_tail_idx;
  state_t     w_state_nxt;
  logic [4:0] w_f_nxt;
  logic       w_dout_nxt;
  logic       w_oe_nxt;
  logic       w_start_nxt;
  logic       w_done_nxt;
  logic       w_abort_nxt;

  assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs_s   = r_cs_sync[SYNC_STAGES-1];

  // r_vld[top] marks the sync chain and edge flop as flushed after reset,
  // so a CS already low through reset is never seen as a fall.
  assign w_sclk_fall = r_sclk_d & ~w_sclk_s;
  assign w_cs_fall   = r_cs_d & ~w_cs_s & r_vld[SYNC_STAGES];
  assign w_cs_rise   = ~r_cs_d & w_cs_s;
  assign w_capture   = (r_state == IDLE) & w_cs_fall;

  assign w_f_inc    = (r_f == 5'd31) ? r_f : r_f + 5'd1;
  assign w_msb_idx  = 4'(5'd14 - w_f_inc);
  assign w_tail_idx = 4'(w_f_inc - 5'd14);

  // Pin synchronizers plus one edge-detect flop per pin
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '1;
      r_vld       <= '0;
      r_sclk_d    <= 1'b0;
      r_cs_d      <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk_pin};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_pin_n};
      r_vld       <= {r_vld[SYNC_STAGES-1:0], 1'b1};
      r_sclk_d    <= w_sclk_s;
      r_cs_d      <= w_cs_s;
    end
  end

  // Hold register and frame capture (sample_in bypasses the hold)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold  <= '0;
      r_shift <= '0;
    end else begin
      if (sample_valid) r_hold <= sample_in;
      if (w_capture) r_shift <= sample_valid ? sample_in : r_hold;
    end
  end

  // State, counter and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_f     <= '0;
      r_dout  <= 1'b0;
      r_oe    <= 1'b0;
      r_start <= 1'b0;
      r_done  <= 1'b0;
      r_abort <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_f     <= w_f_nxt;
      r_dout  <= w_dout_nxt;
      r_oe    <= w_oe_nxt;
      r_start <= w_start_nxt;
      r_done  <= w_done_nxt;
      r_abort <= w_abort_nxt;
    end
  end

  // Next-state: CS rise beats a same-cycle sclk fall
  always_comb begin
    w_state_nxt = r_state;
    w_f_nxt     = r_f;
    w_dout_nxt  = r_dout;
    w_oe_nxt    = r_oe;
    w_start_nxt = 1'b0;
    w_done_nxt  = 1'b0;
    w_abort_nxt = 1'b0;
    if (r_state == IDLE) begin
      if (w_cs_fall) begin
        w_state_nxt = SAMPLE;
        w_f_nxt     = '0;
        w_start_nxt = 1'b1;
        w_oe_nxt    = 1'b0;
        w_dout_nxt  = 1'b0;
      end
    end else if (w_cs_rise) begin
      w_state_nxt = IDLE;
      w_oe_nxt    = 1'b0;
      w_dout_nxt  = 1'b0;
      if (r_f >= 5'd14) w_done_nxt = 1'b1;
      else w_abort_nxt = 1'b1;
    end else if (w_sclk_fall) begin
      w_f_nxt = w_f_inc;
      unique case (r_state)
        SAMPLE: begin
          if (w_f_inc == 5'd2) begin
            w_state_nxt = NULLB;
            w_oe_nxt    = 1'b1;
            w_dout_nxt  = 1'b0;
          end
        end
        NULLB: begin
          w_state_nxt = MSB;
          w_dout_nxt  = r_shift[11];
        end
        MSB: begin
          if (w_f_inc == 5'd15) begin
            if (TAIL_EN) begin
              w_state_nxt = TAIL;
              w_dout_nxt  = r_shift[1];
            end else begin
              w_state_nxt = ZERO;
              w_dout_nxt  = 1'b0;
            end
          end else begin
            w_dout_nxt = r_shift[w_msb_idx];
          end
        end
        TAIL: begin
          if (w_f_inc >= 5'd26) begin
            w_state_nxt = ZERO;
            w_dout_nxt  = 1'b0;
          end else begin
            w_dout_nxt = r_shift[w_tail_idx];
          end
        end
        ZERO: w_dout_nxt = 1'b0;
        default: ;
      endcase
    end
  end

  assign dout_pin    = r_dout;
  assign dout_oe     = r_oe;
  assign busy        = (r_state != IDLE);
  assign conv_start  = r_start;
  assign frame_done  = r_done;
  assign frame_abort = r_abort;

endmodule

// File: doc/mcp3201_emu.md
MCP3201_EMU -- requirements
Module: mcp3201_emu

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of synchronizer flops on sclk_pin and cs_pin_n; legal range 2-3.
REQ-002 Parameter TAIL_EN, default 1: 1 = send the LSB-first tail after B0; 0 = drive 0 after B0.
REQ-003 clk  input  1  single system clock; all logic is on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 sample_in  input  12  next conversion value, unsigned.
REQ-006 sample_valid  input  1  when high, sample_in loads the hold register.
REQ-007 sclk_pin  input  1  SPI clock from the master, asynchronous to clk.
REQ-008 cs_pin_n  input  1  chip select from the master, active-low, asynchronous to clk.
REQ-009 dout_pin  output  1  serial data to the master.
REQ-010 dout_oe  output  1  tri-state enable for dout_pin; 1 = driven.
REQ-011 busy  output  1  high while a frame is in progress (state != IDLE).
REQ-012 conv_start  output  1  one-clk pulse on a detected CS falling edge.
REQ-013 frame_done  output  1  one-clk pulse on CS rise after B0 has been driven.
REQ-014 frame_abort  output  1  one-clk pulse on CS rise before B0 has been driven.

Function
REQ-015 Synchronization: sclk_pin and cs_pin_n each pass through SYNC_STAGES flops, then one edge-detect flop. Synchronizer reset values: sclk 0, cs_n 1.
REQ-016 Clock ratio: correct operation requires clk >= 8x the sclk frequency; nothing outside this range is guaranteed.
REQ-017 Hold register: 12-bit; loads sample_in on any cycle with sample_valid=1, in any state.
REQ-018 Capture: on a detected CS fall, the shift register loads the hold register. If sample_valid=1 in the same cycle, sample_in is loaded directly (bypass).
REQ-019 Falling-edge counter f: 5-bit; cleared on CS fall; increments on each detected sclk fall while CS is low; saturates at 31.
REQ-020 State machine states: IDLE, SAMPLE, NULLB, MSB, TAIL, ZERO.
REQ-021 IDLE -> SAMPLE on CS fall; conv_start pulses; dout_oe stays 0.
REQ-022 SAMPLE: dout_oe=0. On f=2 -> NULLB, with dout_oe=1 and dout_pin=0.
REQ-023 NULLB: on f=3 -> MSB, drive B11.
REQ-024 MSB: f=3..14 drive B11..B0 in order (B(14-f)).
REQ-025 MSB exit at f=15: -> TAIL if TAIL_EN=1, else -> ZERO.
REQ-026 TAIL: f=15..25 drive B1..B11 (B(f-14)); at f=26 -> ZERO.
REQ-027 ZERO: dout_pin=0, dout_oe=1 until CS rise.
REQ-028 dout_pin changes only in the clk cycle following a detected sclk fall, so latency from the sclk_pin fall is SYNC_STAGES+1 clk cycles. This keeps data stable at the master's rising-edge sample.
REQ-029 CS rise in any non-IDLE state -> IDLE in the same clk; dout_oe=0, dout_pin=0 on the next clk.
REQ-030 On that CS rise, frame_done pulses if f>=14, otherwise frame_abort pulses; exactly one of the two fires per frame.
REQ-031 sclk edges detected while CS is high are ignored.
REQ-032 A CS fall detected while in IDLE always starts a new frame.
REQ-033 Simultaneous sclk fall and CS rise in one cycle: CS rise wins and no bit is shifted.
REQ-034 An sclk rise is never acted on.

Reset
REQ-035 While rst is high, all of the following are forced asynchronously: state IDLE, f=0, hold and shift registers 0, dout_pin=0, dout_oe=0, busy=0, conv_start=0, frame_done=0, frame_abort=0.
REQ-036 Reset asserted mid-frame ends the frame with no frame_done and no frame_abort pulse.
REQ-037 After reset release, a frame starts only on a new CS fall seen through the synchronizers; a cs_pin_n held low through reset starts no frame.

Verification
REQ-038 Full frame: hold=0xA5C, 15 sclk falls, CS rise -> master samples null 0 then 1010_0101_1100; frame_done=1 pulse; busy returns to 0.
REQ-039 Tail: hold=0x801, TAIL_EN=1, 26 falls -> after B0 the bits read 0,0,0,0,0,0,0,0,0,0,1 (B1..B11), then 0.
REQ-040 Abort: CS rise after 6 sclk falls -> frame_abort pulse, no frame_done, dout_oe=0 one clk later.
REQ-041 Bypass: sample_valid=1 with sample_in=0x3FF in the CS-fall cycle, hold=0x000 -> frame shifts out 0x3FF.
REQ-042 Reset mid-frame: rst pulse after 8 falls -> dout_oe=0 immediately, no done or abort pulse; the next frame is correct.
REQ-043 Idle noise: 20 sclk toggles with CS high -> dout_oe stays 0, busy stays 0, no pulses.
